tlb_array: RTL and testbench
============================

# tlb_array

Joint 16-entry MIPS TLB that answers the TLB requests of the CP0 block: TLBWI/TLBWR writes from EntryHi/EntryLo0/EntryLo1, TLBR reads into CP0, and TLBP probes that update Index. It also serves two translation lookup ports, fetch (s0) and data (s1), each with a registered one-cycle result. It keeps the free-running Random counter used by TLBWR.

## Interface
- `TLBNUM`, 16: number of entries; index width is `$clog2(TLBNUM)` = 4.
- `clk`  in  1: clock.
- `resetn`  in  1: asynchronous, active-low reset.
- `s0_req` / `s1_req`  in  1: lookup request on the fetch / data port.
- `s0_vpn2` / `s1_vpn2`  in  19: VA[31:13].
- `s0_odd` / `s1_odd`  in  1: VA[12]; selects the even (0) or odd (1) page.
- `s0_asid` / `s1_asid`  in  8: current ASID.
- `s0_found` / `s1_found`  out  1: registered hit.
- `s0_index` / `s1_index`  out  4: registered hit index.
- `s0_pfn` / `s1_pfn`  out  20: registered PFN of the selected page.
- `s0_c` / `s1_c`  out  3, `s0_d` / `s1_d`  out  1, `s0_v` / `s1_v`  out  1: registered C, D and V of the selected page.
- `tlbwi`  in  1: write the entry at `cp0_index[3:0]`.
- `tlbwr`  in  1: write the entry at `random`.
- `cp0_index`, `cp0_entryhi`, `cp0_entrylo0`, `cp0_entrylo1`  in  32 each: CP0 register images.
- `r_index`  in  4: TLBR entry select.
- `r_data`  out  78: combinational packed entry for `TLB_rdata`.
- `p_req`  in  1: TLBP request, a one-cycle pulse.
- `p_done`  out  1: probe result is valid; drives CP0 `is_TLBP`.
- `p_notfound`  out  1: drives `index_write_p`.
- `p_index`  out  4: drives `index_write_index`.
- `random`  out  4: current Random value.

## Operation
- **Entry packing**, `r_data` and internal storage:
  - [77:59] VPN2, [58:51] ASID, [50] G.
  - [49:30] PFN0, [29:27] C0, [26] D0, [25] V0.
  - [24:5] PFN1, [4:2] C1, [1] D1, [0] V1.
- **Write** (TLBWI/TLBWR):
  - VPN2 = entryhi[31:13], ASID = entryhi[7:0].
  - PFNx = lox[25:6], Cx = lox[5:3], Dx = lox[2], Vx = lox[1].
  - G = entrylo0[0] & entrylo1[0].
  - If `tlbwi` and `tlbwr` are both asserted, `tlbwi` wins; exactly one entry is written.
- **Match rule:** entry i hits when VPN2 is equal AND (G OR ASID is equal).
  - Multiple hits are architecturally undefined; the lowest index wins.
  - The V bit does not gate `found`; the core raises TLB Invalid from `v`.
- **Lookup:** compare in the request cycle, register the result at the next edge.
  - If `sN_req` = 0, the outputs hold their previous value.
  - `odd` selects the page-0 or page-1 fields.
- **Probe:** compare `cp0_entryhi` VPN2 and ASID in the `p_req` cycle.
  - Next cycle: `p_done` = 1 for exactly one cycle.
  - `p_notfound` = !hit; `p_index` = hit index, or 0 on a miss.
  - A `p_req` while `p_done` = 1 is legal; it yields back-to-back results.
- **Read:** `r_data` = entry[`r_index`], combinational, so CP0 latches it in the same cycle as `is_TLBR`.
- **Random:** decrements by 1 every cycle and wraps 0 → 15. It is not affected by writes.

## Timing
- **Reset values:**
  - All entry fields are 0.
  - All s0/s1 outputs are 0; `p_done`, `p_notfound` and `p_index` are 0.
  - `random` = 15.
- **Latency:**
  - Lookup: 1 cycle.
  - Probe: 1 cycle, pulsed.
  - Read: 0 cycles.
  - Write: visible to lookup, probe and read from the cycle after the write edge.
- **Same-cycle write with lookup, probe or read:** these see the old contents (read-before-write). The result reflects the new entry only one cycle later.
- **Reset mid-operation:** asserting `resetn` low clears all state immediately, including a pending `p_done`. No result is produced for a request in flight.
- **After reset:** a lookup of VPN2=0, ASID=0 hits entry 0 with V=0. This is intended.

## Structure
- **Package `tlb_pkg`:**
  - `TLBNUM` and `TLB_IDX_W`.
  - Bit-position localparams for every packed field.
  - A packed-struct typedef for the entry and for the lookup result.
- **Sub-module `tlb_match`:** combinational.
  - Inputs: vpn2, asid, the entry array. Outputs: hit and lowest-index encoded index.
  - Instantiated three times: s0, s1 and probe.
- **Top module:** storage flops, write decode, output registers, Random counter.

## Test plan
- **Reset → TLBR:** reset, then `r_index`=5 → `r_data`=0; `random`=15, then 14 and 13 on the next two edges, 0 → 15 wrap on the 16th edge.
- **TLBWI → read and odd-page lookup:**
  - Stimulus: TLBWI to index 3 with entryhi=0x0040_0012, lo0=0x0000_1047, lo1=0x0000_2057.
  - Expected: `r_data` VPN2=0x00200, ASID=0x12, G=1, PFN0=0x41.
  - Then s1 lookup vpn2=0x00200, odd=1, asid=0x99 → next cycle found=1, index=3, pfn=0x81, c=2, d=1, v=1 (global, so ASID ignored).
- **ASID mismatch / TLBP miss:**
  - Stimulus: write index 7, vpn2=0x1, asid=0x05, G=0.
  - Lookup with asid=0x06 → found=0.
  - TLBP with entryhi asid=0x05 → `p_done` pulse, `p_notfound`=0, `p_index`=7.
  - TLBP with asid=0x06 → `p_notfound`=1, `p_index`=0.
- **Simultaneous events:**
  - TLBWI to index 2 and s0 lookup of the new VPN2 in the same cycle → found=0.
  - Repeat the lookup next cycle → found=1, index=2.
  - `tlbwi` and `tlbwr` together → only `cp0_index` is written; the random slot is unchanged.
- **Duplicate hit and async reset:**
  - Identical entries written at 4 and 9 → lookup index=4.
  - `resetn` low during a `p_req` cycle → no `p_done`; all outputs read 0 after release.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared types and field layout for the 16-entry joint TLB.
// The packed entry layout is also the TLBR image that CP0 latches.
package tlb_pkg;

    localparam int TLBNUM    = 16;
    localparam int TLB_IDX_W = $clog2(TLBNUM);
    localparam int ENTRY_W   = 78;

    localparam int VPN2_MSB = 77;
    localparam int VPN2_LSB = 59;
    localparam int ASID_MSB = 58;
    localparam int ASID_LSB = 51;
    localparam int G_BIT    = 50;
    localparam int PFN0_MSB = 49;
    localparam int PFN0_LSB = 30;
    localparam int C0_MSB   = 29;
    localparam int C0_LSB   = 27;
    localparam int D0_BIT   = 26;
    localparam int V0_BIT   = 25;
    localparam int PFN1_MSB = 24;
    localparam int PFN1_LSB = 5;
    localparam int C1_MSB   = 4;
    localparam int C1_LSB   = 2;
    localparam int D1_BIT   = 1;
    localparam int V1_BIT   = 0;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
    } tlb_tag_t;

    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        tlb_tag_t  tag;
        tlb_page_t p0;
        tlb_page_t p1;
    } tlb_entry_t;

    typedef struct packed {
        logic                 found;
        logic [TLB_IDX_W-1:0] index;
        tlb_page_t            page;
    } tlb_result_t;

endpackage

// File: rtl/tlb_match.sv
// Combinational associative compare of one VPN2/ASID against every entry tag.
// Returns the lowest matching index when several entries hit.
module tlb_match
    import tlb_pkg::*;
(
    input  logic [18:0]          vpn2,
    input  logic [7:0]           asid,
    input  tlb_tag_t             tags [TLBNUM],
    output logic                 hit,
    output logic [TLB_IDX_W-1:0] index
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        hit   = 1'b0;
        index = '0;
        // Scanning downwards lets the lowest matching index overwrite the others.
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (tags[i].vpn2 == vpn2 && (tags[i].g || tags[i].asid == asid)) begin
                hit   = 1'b1;
                index = TLB_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tlb_array.sv
// Joint MIPS TLB: CP0 write/read/probe, two registered lookup ports and Random.
// All lookups and probes compare against pre-write contents in a write cycle.
module tlb_array
    import tlb_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,

    input  logic                 s0_req,
    input  logic [18:0]          s0_vpn2,
    input  logic                 s0_odd,
    input  logic [7:0]           s0_asid,
    output logic                 s0_found,
    output logic [TLB_IDX_W-1:0] s0_index,
    output logic [19:0]          s0_pfn,
    output logic [2:0]           s0_c,
    output logic                 s0_d,
    output logic                 s0_v,

    input  logic                 s1_req,
    input  logic [18:0]          s1_vpn2,
    input  logic                 s1_odd,
    input  logic [7:0]           s1_asid,
    output logic                 s1_found,
    output logic [TLB_IDX_W-1:0] s1_index,
    output logic [19:0]          s1_pfn,
    output logic [2:0]           s1_c,
    output logic                 s1_d,
    output logic                 s1_v,

    input  logic                 tlbwi,
    input  logic                 tlbwr,
    input  logic [31:0]          cp0_index,
    input  logic [31:0]          cp0_entryhi,
    input  logic [31:0]          cp0_entrylo0,
    input  logic [31:0]          cp0_entrylo1,

    input  logic [TLB_IDX_W-1:0] r_index,
    output logic [ENTRY_W-1:0]   r_data,

    input  logic                 p_req,
    output logic                 p_done,
    output logic                 p_notfound,
    output logic [TLB_IDX_W-1:0] p_index,

    output logic [TLB_IDX_W-1:0] random
);

    tlb_entry_t           entries [TLBNUM];
    tlb_tag_t             tags    [TLBNUM];
    tlb_entry_t           wr_entry;
    logic [ENTRY_W-1:0]   wr_bits;
    logic                 wr_en;
    logic [TLB_IDX_W-1:0] wr_idx;

    logic                 s0_hit, s1_hit, p_hit;
    logic [TLB_IDX_W-1:0] s0_hit_idx, s1_hit_idx, p_hit_idx;
    tlb_result_t          s0_next, s1_next, s0_res, s1_res;

    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{cp0_index[31:TLB_IDX_W], cp0_entryhi[12:8],
                               cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

    // Field placement follows the TLBR image so r_data is a plain view of storage.
    always_comb begin
        wr_bits                     = '0;
        wr_bits[VPN2_MSB:VPN2_LSB]  = cp0_entryhi[31:13];
        wr_bits[ASID_MSB:ASID_LSB]  = cp0_entryhi[7:0];
        wr_bits[G_BIT]              = cp0_entrylo0[0] & cp0_entrylo1[0];
        wr_bits[PFN0_MSB:PFN0_LSB]  = cp0_entrylo0[25:6];
        wr_bits[C0_MSB:C0_LSB]      = cp0_entrylo0[5:3];
        wr_bits[D0_BIT]             = cp0_entrylo0[2];
        wr_bits[V0_BIT]             = cp0_entrylo0[1];
        wr_bits[PFN1_MSB:PFN1_LSB]  = cp0_entrylo1[25:6];
        wr_bits[C1_MSB:C1_LSB]      = cp0_entrylo1[5:3];
        wr_bits[D1_BIT]             = cp0_entrylo1[2];
        wr_bits[V1_BIT]             = cp0_entrylo1[1];
        wr_entry                    = tlb_entry_t'(wr_bits);
    end

    assign wr_en  = tlbwi | tlbwr;
    assign wr_idx = tlbwi ? cp0_index[TLB_IDX_W-1:0] : random;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: storage is reset because a lookup right after reset must hit a defined all-zero entry 0.
            for (int i = 0; i < TLBNUM; i++) entries[i] <= '0;
        end else if (wr_en) begin
            // NOTE: non-blocking so same-edge readers of entries see the old contents.
            entries[wr_idx] <= wr_entry;
        end
    end

    always_comb begin
        for (int i = 0; i < TLBNUM; i++) tags[i] = entries[i].tag;
    end

    assign r_data = entries[r_index];

    tlb_match u_match_s0 (.vpn2(s0_vpn2), .asid(s0_asid), .tags(tags),
                          .hit(s0_hit), .index(s0_hit_idx));
    tlb_match u_match_s1 (.vpn2(s1_vpn2), .asid(s1_asid), .tags(tags),
                          .hit(s1_hit), .index(s1_hit_idx));
    tlb_match u_match_p  (.vpn2(cp0_entryhi[31:13]), .asid(cp0_entryhi[7:0]), .tags(tags),
                          .hit(p_hit), .index(p_hit_idx));

    // V is deliberately passed through rather than gating found; the core raises TLB Invalid.
    always_comb begin
        s0_next.found = s0_hit;
        s0_next.index = s0_hit_idx;
        s0_next.page  = s0_odd ? entries[s0_hit_idx].p1 : entries[s0_hit_idx].p0;
        s1_next.found = s1_hit;
        s1_next.index = s1_hit_idx;
        s1_next.page  = s1_odd ? entries[s1_hit_idx].p1 : entries[s1_hit_idx].p0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s0_res <= '0;
            s1_res <= '0;
        end else begin
            if (s0_req) s0_res <= s0_next;
            if (s1_req) s1_res <= s1_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_done     <= 1'b0;
            p_notfound <= 1'b0;
            p_index    <= '0;
        end else begin
            p_done <= p_req;
            if (p_req) begin
                p_notfound <= !p_hit;
                p_index    <= p_hit ? p_hit_idx : '0;
            end
        end
    end

    // Free-running down counter; 4-bit wrap gives 0 -> 15 for free.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) random <= '1;
        else         random <= random - 1'b1;
    end

    assign s0_found = s0_res.found;
    assign s0_index = s0_res.index;
    assign s0_pfn   = s0_res.page.pfn;
    assign s0_c     = s0_res.page.c;
    assign s0_d     = s0_res.page.d;
    assign s0_v     = s0_res.page.v;
    assign s1_found = s1_res.found;
    assign s1_index = s1_res.index;
    assign s1_pfn   = s1_res.page.pfn;
    assign s1_c     = s1_res.page.c;
    assign s1_d     = s1_res.page.d;
    assign s1_v     = s1_res.page.v;

endmodule

// File: tb/tb_tlb_array.sv
// Directed self-checking bench for tlb_array: reset, writes, lookups, probes, Random.
module tb_tlb_array;

    logic        clk = 1'b0;
    logic        resetn;
    logic        s0_req, s0_odd, s1_req, s1_odd;
    logic [18:0] s0_vpn2, s1_vpn2;
    logic [7:0]  s0_asid, s1_asid;
    logic        s0_found, s0_d, s0_v, s1_found, s1_d, s1_v;
    logic [3:0]  s0_index, s1_index;
    logic [19:0] s0_pfn, s1_pfn;
    logic [2:0]  s0_c, s1_c;
    logic        tlbwi, tlbwr;
    logic [31:0] cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
    logic [3:0]  r_index;
    logic [77:0] r_data;
    logic        p_req, p_done, p_notfound;
    logic [3:0]  p_index, random;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  exp_rand;
    logic [77:0] exp_mem [16];
    logic [3:0]  r_slot, w_slot;

    // Hand-packed entry images: {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1}
    localparam logic [77:0] E3  = {19'h00200, 8'h12, 1'b1, 20'h00041, 3'd0, 1'b1, 1'b1, 20'h00081, 3'd2, 1'b1, 1'b1};
    localparam logic [77:0] E7  = {19'h00001, 8'h05, 1'b0, 20'h00002, 3'd0, 1'b1, 1'b1, 20'h00003, 3'd0, 1'b1, 1'b0};
    localparam logic [77:0] E2  = {19'h00003, 8'h01, 1'b0, 20'h00005, 3'd0, 1'b0, 1'b1, 20'h00000, 3'd0, 1'b0, 1'b0};
    localparam logic [77:0] EWR = {19'h00050, 8'h33, 1'b0, 20'h00001, 3'd0, 1'b1, 1'b1, 20'h00002, 3'd0, 1'b1, 1'b1};

    tlb_array dut (
        .clk(clk), .resetn(resetn),
        .s0_req(s0_req), .s0_vpn2(s0_vpn2), .s0_odd(s0_odd), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_req(s1_req), .s1_vpn2(s1_vpn2), .s1_odd(s1_odd), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .tlbwi(tlbwi), .tlbwr(tlbwr), .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi),
        .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
        .r_index(r_index), .r_data(r_data),
        .p_req(p_req), .p_done(p_done), .p_notfound(p_notfound), .p_index(p_index),
        .random(random)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [77:0] observed, input logic [77:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle; the bench's own Random model steps with it.
    task automatic tick();
        @(posedge clk);
        #1;
        exp_rand = exp_rand - 4'd1;
    endtask

    task automatic do_write(input logic [3:0] idx, input logic [31:0] hi, input logic [31:0] lo0,
                            input logic [31:0] lo1);
        cp0_index    = {28'd0, idx};
        cp0_entryhi  = hi;
        cp0_entrylo0 = lo0;
        cp0_entrylo1 = lo1;
        tlbwi        = 1'b1;
        tick();
        tlbwi        = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        s0_req = 0; s0_odd = 0; s0_vpn2 = '0; s0_asid = '0;
        s1_req = 0; s1_odd = 0; s1_vpn2 = '0; s1_asid = '0;
        tlbwi = 0; tlbwr = 0; cp0_index = '0; cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0;
        r_index = '0; p_req = 0;
        exp_rand = 4'd15;
        for (int i = 0; i < 16; i++) exp_mem[i] = '0;

        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        exp_rand = 4'd15;

        // Reset state, TLBR of an untouched slot, Random countdown and wrap
        r_index = 4'd5;
        #1;
        check("reset_rdata", r_data, 78'd0);
        check("reset_random", {74'd0, random}, 78'd15);
        check("reset_outputs", {60'd0, s0_found, s1_found, p_done, p_notfound, p_index, s1_index, s1_pfn}, 78'd0);
        tick();
        check("random_14", {74'd0, random}, 78'd14);
        tick();
        check("random_13", {74'd0, random}, 78'd13);
        repeat (13) tick();
        check("random_0", {74'd0, random}, 78'd0);
        tick();
        check("random_wrap", {74'd0, random}, 78'd15);

        // TLBWI index 3, global entry; read back and odd-page lookup with foreign ASID
        do_write(4'd3, 32'h0040_0012, 32'h0000_1047, 32'h0000_2057);
        exp_mem[3] = E3;
        r_index = 4'd3;
        #1;
        check("tlbr_idx3", r_data, E3);
        s1_req = 1; s1_vpn2 = 19'h00200; s1_odd = 1; s1_asid = 8'h99;
        tick();
        s1_req = 0;
        check("s1_global_hit", {44'd0, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v},
              {44'd0, 1'b1, 4'd3, 20'h00081, 3'd2, 1'b1, 1'b1});
        s1_vpn2 = 19'h7ffff;
        tick();
        check("s1_hold_no_req", {77'd0, s1_found}, 78'd1);

        // Non-global entry at 7: ASID mismatch, ASID match, probes
        do_write(4'd7, 32'h0000_2005, 32'h0000_0086, 32'h0000_00C4);
        exp_mem[7] = E7;
        s0_req = 1; s0_vpn2 = 19'h1; s0_odd = 0; s0_asid = 8'h06;
        tick();
        check("s0_asid_miss", {77'd0, s0_found}, 78'd0);
        s0_asid = 8'h05;
        tick();
        s0_req = 0;
        check("s0_asid_hit", {44'd0, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v},
              {44'd0, 1'b1, 4'd7, 20'h00002, 3'd0, 1'b1, 1'b1});

        cp0_entryhi = 32'h0000_2005;
        p_req = 1;
        tick();
        p_req = 0;
        check("tlbp_hit", {72'd0, p_done, p_notfound, p_index}, {72'd0, 1'b1, 1'b0, 4'd7});
        tick();
        check("tlbp_pulse_end", {77'd0, p_done}, 78'd0);
        cp0_entryhi = 32'h0000_2006;
        p_req = 1;
        tick();
        p_req = 0;
        check("tlbp_miss", {72'd0, p_done, p_notfound, p_index}, {72'd0, 1'b1, 1'b1, 4'd0});

        // Back-to-back probes: hit then miss
        cp0_entryhi = 32'h0000_2005;
        p_req = 1;
        tick();
        check("tlbp_b2b_first", {72'd0, p_done, p_notfound, p_index}, {72'd0, 1'b1, 1'b0, 4'd7});
        cp0_entryhi = 32'h0000_2006;
        tick();
        p_req = 0;
        check("tlbp_b2b_second", {72'd0, p_done, p_notfound, p_index}, {72'd0, 1'b1, 1'b1, 4'd0});

        // Write and lookup in the same cycle: old contents first, new one cycle later
        s0_req = 1; s0_vpn2 = 19'h3; s0_odd = 0; s0_asid = 8'h01;
        do_write(4'd2, 32'h0000_6001, 32'h0000_0142, 32'h0000_0000);
        exp_mem[2] = E2;
        check("same_cycle_old", {77'd0, s0_found}, 78'd0);
        tick();
        s0_req = 0;
        check("next_cycle_new", {52'd0, s0_found, s0_index, s0_pfn, s0_v},
              {52'd0, 1'b1, 4'd2, 20'h00005, 1'b1});

        // tlbwi and tlbwr together: only cp0_index slot is written
        check("random_model", {74'd0, random}, {74'd0, exp_rand});
        r_slot = exp_rand;
        w_slot = r_slot ^ 4'h8;
        cp0_index = {28'd0, w_slot};
        cp0_entryhi = 32'h000A_0033; cp0_entrylo0 = 32'h0000_0046; cp0_entrylo1 = 32'h0000_0086;
        tlbwi = 1; tlbwr = 1;
        tick();
        tlbwi = 0; tlbwr = 0;
        exp_mem[w_slot] = EWR;
        r_index = w_slot;
        #1;
        check("wiwr_index_slot", r_data, exp_mem[w_slot]);
        r_index = r_slot;
        #1;
        check("wiwr_random_slot", r_data, exp_mem[r_slot]);

        // Duplicate entries at 4 and 9: lowest index wins
        do_write(4'd9, 32'h000F_E044, 32'h0000_0042, 32'h0000_0082);
        do_write(4'd4, 32'h000F_E044, 32'h0000_0042, 32'h0000_0082);
        s1_req = 1; s1_vpn2 = 19'h0007F; s1_odd = 1; s1_asid = 8'h44;
        tick();
        s1_req = 0;
        check("dup_lowest", {53'd0, s1_found, s1_index, s1_pfn}, {53'd0, 1'b1, 4'd4, 20'h00002});

        // Async reset during a probe request cycle
        cp0_entryhi = 32'h0000_2005;
        p_req = 1;
        #2 resetn = 1'b0;
        #1;
        check("reset_async_clear", {76'd0, s1_found, p_notfound}, 78'd0);
        @(posedge clk);
        #1;
        check("reset_no_pdone", {77'd0, p_done}, 78'd0);
        p_req = 0;
        @(posedge clk);
        #1 resetn = 1'b1;
        exp_rand = 4'd15;
        r_index = 4'd4;
        #1;
        check("post_reset_outs", {49'd0, s0_found, s0_index, s1_found, s1_index, s1_pfn, p_done, p_notfound, p_index},
              78'd0);
        check("post_reset_rdata", r_data, 78'd0);
        check("post_reset_random", {74'd0, random}, 78'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
